// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for MEM-stage loads/stores: WAIT_CYCLES wait states,
// then a one-cycle ready pulse with registered rdata/err; busy freezes the pipeline meanwhile.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_be,
  output logic        o_busy,
  output logic        o_ready,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_cnt;
  logic [3:0]              w_cnt_nxt;
  logic                    w_accept;
  logic                    w_commit;

  logic                    r_we;
  logic [31:0]             r_addr;
  logic [31:0]             r_wdata;
  logic [3:0]              r_be;
  logic                    r_ready;
  logic [31:0]             r_rdata;
  logic                    r_err;

  logic [31:0]             r_mem [DEPTH];

  logic                    w_eff_we;
  logic [31:0]             w_eff_addr;
  logic [31:0]             w_eff_wdata;
  logic [3:0]              w_eff_be;
  logic                    w_reject;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic [31:0]             w_old;
  logic [31:0]             w_merged;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_commit    = 1'b1;
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_commit    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_busy = ((r_state == S_IDLE) && i_req) || (r_state == S_WAIT);

  // With zero wait states the commit happens on the accept edge, so the live inputs are used.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_eff_we    = i_we;
      w_eff_addr  = i_addr;
      w_eff_wdata = i_wdata;
      w_eff_be    = i_be;
    end else begin
      w_eff_we    = r_we;
      w_eff_addr  = r_addr;
      w_eff_wdata = r_wdata;
      w_eff_be    = r_be;
    end
  end

  assign w_reject = (w_eff_addr[1:0] != 2'b00) || ((w_eff_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign w_idx    = w_eff_addr[ADDR_WIDTH+1:2];
  assign w_old    = r_mem[w_idx];

  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < 4; i++) begin
      if (w_eff_be[i]) begin
        w_merged[8*i +: 8] = w_eff_wdata[8*i +: 8];
      end
    end
  end

  // Array is not reset; the reset gate drops a store whose commit edge lands inside reset.
  always_ff @(posedge i_clk) begin
    if (i_reset && w_commit && w_eff_we && !w_reject) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_commit;
      if (w_accept) begin
        r_we    <= i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_be    <= i_be;
      end
      if (w_commit) begin
        r_err   <= w_reject;
        r_rdata <= w_reject ? 32'd0 : w_old;
      end
    end
  end

  assign o_ready = r_ready;
  assign o_rdata = r_rdata;
  assign o_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: transaction-level timing/memory model checked every cycle,
// plus directed vectors with literal expectations; a second instance covers zero wait states.
module tb_dmem_responder;

  localparam int AW = 6;
  localparam int W  = 2;

  logic        clk = 1'b0;
  logic        t_reset, t_req, t_we;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_be;
  logic        d_busy, d_ready, d_err;
  logic [31:0] d_rdata;

  logic        z_req, z_we;
  logic [31:0] z_addr, z_wdata;
  logic [3:0]  z_be;
  logic        z_busy, z_ready, z_err;
  logic [31:0] z_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
    .i_clk(clk), .i_reset(t_reset), .i_req(t_req), .i_we(t_we), .i_addr(t_addr),
    .i_wdata(t_wdata), .i_be(t_be), .o_busy(d_busy), .o_ready(d_ready),
    .o_rdata(d_rdata), .o_err(d_err)
  );

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_reset(t_reset), .i_req(z_req), .i_we(z_we), .i_addr(z_addr),
    .i_wdata(z_wdata), .i_be(z_be), .o_busy(z_busy), .o_ready(z_ready),
    .o_rdata(z_rdata), .o_err(z_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: memory with per-bit knownness, and the accept edge of the current access.
  bit [31:0] m_mem   [64];
  bit [31:0] m_known [64];
  bit        m_pend  = 1'b0;
  int        m_acc   = 0;
  int        e       = 0;
  bit        s_we;
  bit [31:0] s_addr, s_wdata;
  bit [3:0]  s_be;
  bit [31:0] m_rdata = 32'd0;
  bit [31:0] m_rmask = 32'hFFFF_FFFF;
  bit        m_err   = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      e++;
      if (!t_reset) begin
        m_pend  = 1'b0;
        m_rdata = 32'd0;
        m_rmask = 32'hFFFF_FFFF;
        m_err   = 1'b0;
      end else begin
        if (m_pend && e == m_acc + W) begin
          if (s_addr[1:0] != 2'b00 || s_addr >= 32'(4 << AW)) begin
            m_err   = 1'b1;
            m_rdata = 32'd0;
            m_rmask = 32'hFFFF_FFFF;
          end else begin
            m_err   = 1'b0;
            m_rdata = m_mem[s_addr[AW+1:2]];
            m_rmask = m_known[s_addr[AW+1:2]];
            if (s_we) begin
              for (int b = 0; b < 4; b++) begin
                if (s_be[b]) begin
                  m_mem[s_addr[AW+1:2]][8*b +: 8]   = s_wdata[8*b +: 8];
                  m_known[s_addr[AW+1:2]][8*b +: 8] = 8'hFF;
                end
              end
            end
          end
        end
        if ((!m_pend || e > m_acc + W + 1) && t_req) begin
          m_pend  = 1'b1;
          m_acc   = e;
          s_we    = t_we;
          s_addr  = t_addr;
          s_wdata = t_wdata;
          s_be    = t_be;
        end
      end
    end
  end

  initial begin
    bit in_wait, in_resp;
    forever begin
      @(negedge clk);
      if (!t_reset) begin
        chk("rst_ready", 32'(d_ready), 32'd0);
        chk("rst_busy",  32'(d_busy),  32'(t_req));
        chk("rst_rdata", d_rdata,      32'd0);
        chk("rst_err",   32'(d_err),   32'd0);
      end else begin
        in_wait = m_pend && e >= m_acc && e < m_acc + W;
        in_resp = m_pend && e == m_acc + W;
        chk("cyc_ready", 32'(d_ready), 32'(in_resp));
        chk("cyc_busy",  32'(d_busy),  in_wait ? 32'd1 : (in_resp ? 32'd0 : 32'(t_req)));
        chk("cyc_rdata", d_rdata & m_rmask, m_rdata & m_rmask);
        chk("cyc_err",   32'(d_err),   32'(m_err));
      end
    end
  end

  // Called and returns at posedge+1 with the DUT idle; scrambles inputs after acceptance.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output logic [31:0] rd, output logic er,
                           output int lat);
    t_req = 1'b1; t_we = we; t_addr = addr; t_wdata = wdata; t_be = be;
    @(posedge clk); #1;
    t_req = 1'b0; t_we = ~we; t_addr = 32'hFFFF_FFFF; t_wdata = ~wdata; t_be = ~be;
    lat = -1; rd = 32'd0; er = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (d_ready) begin
        lat = n; rd = d_rdata; er = d_err;
        break;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual=none required=pulse at %0t", $time);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          np;
    int          pc [3];
    logic [31:0] pd [3];

    t_reset = 1'b0; t_req = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0; t_be = '0;
    z_req = 1'b0; z_we = 1'b0; z_addr = '0; z_wdata = '0; z_be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(d_ready), 32'd0);
    chk("reset_rdata", d_rdata,      32'd0);
    chk("reset_err",   32'(d_err),   32'd0);
    chk("reset_busy",  32'(d_busy),  32'd0);
    @(posedge clk); #1;
    t_reset = 1'b1;

    do_access(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    chk("st10_lat", 32'(lat), 32'd3);
    chk("st10_err", 32'(er),  32'd0);
    do_access(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("ld10_lat",   32'(lat), 32'd3);
    chk("ld10_rdata", rd,       32'hDEAD_BEEF);
    chk("ld10_err",   32'(er),  32'd0);

    do_access(1'b1, 32'h14, 32'h1122_3344, 4'hF, rd, er, lat);
    do_access(1'b1, 32'h14, 32'h0000_AB00, 4'b0010, rd, er, lat);
    chk("pst14_prewrite", rd, 32'h1122_3344);
    do_access(1'b0, 32'h14, 32'h0, 4'h0, rd, er, lat);
    chk("ld14_merged", rd, 32'h1122_AB44);

    do_access(1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF, rd, er, lat);
    do_access(1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat);
    chk("mis_err",   32'(er), 32'd1);
    chk("mis_rdata", rd,      32'd0);
    do_access(1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    chk("oor_err",   32'(er), 32'd1);
    do_access(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    chk("ld0_unchanged", rd, 32'hA5A5_A5A5);
    do_access(1'b1, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("be0_err", 32'(er), 32'd0);
    do_access(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("be0_unchanged", rd, 32'hDEAD_BEEF);

    do_access(1'b1, 32'h20, 32'h2020_2020, 4'hF, rd, er, lat);
    do_access(1'b1, 32'h24, 32'h2424_2424, 4'hF, rd, er, lat);
    do_access(1'b1, 32'h28, 32'h2828_2828, 4'hF, rd, er, lat);
    np = 0;
    t_req = 1'b1; t_we = 1'b0; t_addr = 32'h20;
    for (int c = 0; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 0) t_addr = 32'h24;
      if (c == 4) t_addr = 32'h28;
      if (c == 8) t_addr = 32'h3C;
      @(negedge clk);
      if (d_ready) begin
        if (np < 3) begin
          pc[np] = c;
          pd[np] = d_rdata;
        end
        np++;
      end
    end
    @(posedge clk); #1;
    t_req = 1'b0;
    chk("b2b_count", 32'(np), 32'd3);
    chk("b2b_c0", 32'(pc[0]), 32'd2);
    chk("b2b_c1", 32'(pc[1]), 32'd6);
    chk("b2b_c2", 32'(pc[2]), 32'd10);
    chk("b2b_d0", pd[0], 32'h2020_2020);
    chk("b2b_d1", pd[1], 32'h2424_2424);
    chk("b2b_d2", pd[2], 32'h2828_2828);

    do_access(1'b1, 32'h30, 32'h0BAD_F00D, 4'hF, rd, er, lat);
    t_req = 1'b1; t_we = 1'b1; t_addr = 32'h30; t_wdata = 32'h5555_5555; t_be = 4'hF;
    @(posedge clk); #1;
    t_req = 1'b0;
    @(negedge clk);
    chk("abort_busy_wait", 32'(d_busy), 32'd1);
    @(posedge clk); #1;
    t_reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(d_ready), 32'd0);
    chk("abort_busy",  32'(d_busy),  32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_ready2", 32'(d_ready), 32'd0);
    @(posedge clk); #1;
    t_reset = 1'b1;
    do_access(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
    chk("abort_word_kept", rd, 32'h0BAD_F00D);

    z_req = 1'b1; z_we = 1'b1; z_addr = 32'h8; z_wdata = 32'hCAFE_F00D; z_be = 4'hF;
    @(negedge clk);
    chk("w0_st_busy",  32'(z_busy),  32'd1);
    chk("w0_st_ready", 32'(z_ready), 32'd0);
    @(posedge clk); #1;
    z_req = 1'b0;
    @(negedge clk);
    chk("w0_st_ready1", 32'(z_ready), 32'd1);
    chk("w0_st_busy1",  32'(z_busy),  32'd0);
    chk("w0_st_err",    32'(z_err),   32'd0);
    @(posedge clk); #1;
    z_req = 1'b1; z_we = 1'b0;
    @(negedge clk);
    chk("w0_ld_busy",  32'(z_busy),  32'd1);
    chk("w0_ld_ready", 32'(z_ready), 32'd0);
    @(posedge clk); #1;
    z_req = 1'b0; z_addr = 32'h4;
    @(negedge clk);
    chk("w0_ld_ready1", 32'(z_ready), 32'd1);
    chk("w0_ld_busy1",  32'(z_busy),  32'd0);
    chk("w0_ld_rdata",  z_rdata,      32'hCAFE_F00D);
    chk("w0_ld_err",    32'(z_err),   32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w0_ready_drop", 32'(z_ready), 32'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
